// File: rtl/stop_game_pkg.sv
// rtl/stop_game_pkg.sv - shared types and helpers for the stop-the-counter game
package stop_game_pkg;

  localparam int MAX_LIVES = 8;

  typedef enum logic [2:0] {
    S_COUNT,
    S_JUDGE,
    S_RELEASE,
    S_WON,
    S_LOST
  } state_t;

  function automatic int level_w(input int levels);
    return (levels < 1) ? 1 : $clog2(levels + 1);
  endfunction

  // Thermometer bar sized for the largest supported life count; callers keep the low LIVES bits.
  function automatic logic [MAX_LIVES-1:0] therm(input logic [3:0] lives);
    logic [MAX_LIVES-1:0] bar;
    bar = '0;
    for (int i = 0; i < MAX_LIVES; i++) begin
      bar[i] = (i < int'(lives));
    end
    return bar;
  endfunction

endpackage

// File: rtl/stop_game_if.sv
// rtl/stop_game_if.sv - player controls and board display bundle for stop_game_core
interface stop_game_if #(
  parameter int CNT_W  = 4,
  parameter int LIVES  = 4,
  parameter int LEVELS = 3
);
  localparam int LVL_W = stop_game_pkg::level_w(LEVELS);

  logic             stop_btn;
  logic             restart;
  logic [CNT_W-1:0] counter;
  logic [LIVES-1:0] lives_bar;
  logic [LVL_W-1:0] level;
  logic             hit_pulse;
  logic             miss_pulse;
  logic             won_led;
  logic             lost_led;

  modport master (
    output stop_btn, restart,
    input  counter, lives_bar, level, hit_pulse, miss_pulse, won_led, lost_led
  );

  modport slave (
    input  stop_btn, restart,
    output counter, lives_bar, level, hit_pulse, miss_pulse, won_led, lost_led
  );
endinterface

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - programmable divider producing a one-cycle tick every div enabled cycles
module tick_prescaler #(
  parameter int DIV_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);
  logic [DIV_W-1:0] cnt;

  assign tick = en & (cnt == div - DIV_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + DIV_W'(1);
    end
  end
endmodule

// File: rtl/stop_game_core.sv
// rtl/stop_game_core.sv - multi-level stop-the-counter game; LEVEL_SPEEDUP_EN halves the tick period per cleared level
module stop_game_core
  import stop_game_pkg::*;
#(
  parameter int CNT_W    = 4,
  parameter int TARGET   = 9,
  parameter int LIVES    = 4,
  parameter int LEVELS   = 3,
  parameter int TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  stop_game_if.slave  gif
);
  localparam int               LVL_W      = level_w(LEVELS);
  localparam int               DIV_W      = $clog2(TICK_DIV + 1);
  localparam logic [3:0]       LIVES_INIT = 4'(LIVES);
  localparam logic [LVL_W-1:0] LEVELS_W   = LVL_W'(LEVELS);
  localparam logic [CNT_W-1:0] TARGET_W   = CNT_W'(TARGET);
  localparam logic [DIV_W-1:0] DIV_INIT   = DIV_W'(TICK_DIV);

  state_t               state, state_n;
  logic [CNT_W-1:0]     counter_q, counter_n;
  logic [3:0]           lives_q, lives_n;
  logic [LVL_W-1:0]     level_q, level_n;
  logic                 hit_q, hit_n;
  logic                 miss_q, miss_n;
  logic                 btn_q;
  logic                 stop_edge;
  logic                 counting;
  logic                 presc_clr;
  logic                 tick;
  logic [DIV_W-1:0]     div;
  logic [MAX_LIVES-1:0] bar_full;
  logic                 unused_bar;

`ifdef LEVEL_SPEEDUP_EN
  logic [DIV_W-1:0] div_n;
  logic [DIV_W-1:0] div_scaled;
  assign div_scaled = DIV_INIT >> level_q;
`else
  assign div = DIV_INIT;
`endif

  // btn_q powers up high so a button held through reset or restart needs a release first.
  assign stop_edge = gif.stop_btn & ~btn_q;
  assign counting  = (state == S_COUNT);

  tick_prescaler #(.DIV_W(DIV_W)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (presc_clr),
    .en   (counting),
    .div  (div),
    .tick (tick)
  );

  always_comb begin
    state_n   = state;
    counter_n = counter_q;
    lives_n   = lives_q;
    level_n   = level_q;
    hit_n     = 1'b0;
    miss_n    = 1'b0;
    presc_clr = 1'b0;
`ifdef LEVEL_SPEEDUP_EN
    div_n     = div;
`endif
    if (gif.restart) begin
      state_n   = S_COUNT;
      counter_n = '0;
      lives_n   = LIVES_INIT;
      level_n   = '0;
      presc_clr = 1'b1;
`ifdef LEVEL_SPEEDUP_EN
      div_n     = DIV_INIT;
`endif
    end else begin
      case (state)
        S_COUNT: begin
          // A stop landing on a tick freezes the value the player saw.
          if (stop_edge) begin
            state_n = S_JUDGE;
          end else if (tick) begin
            counter_n = counter_q + CNT_W'(1);
          end
        end
        S_JUDGE: begin
          if (counter_q == TARGET_W) begin
            hit_n   = 1'b1;
            level_n = level_q + LVL_W'(1);
            state_n = (level_n == LEVELS_W) ? S_WON : S_RELEASE;
          end else begin
            miss_n = 1'b1;
            if (lives_q != 4'd0) begin
              lives_n = lives_q - 4'd1;
            end
            state_n = (lives_q <= 4'd1) ? S_LOST : S_RELEASE;
          end
        end
        S_RELEASE: begin
          if (!gif.stop_btn) begin
            counter_n = '0;
            presc_clr = 1'b1;
            state_n   = S_COUNT;
`ifdef LEVEL_SPEEDUP_EN
            div_n     = (div_scaled == '0) ? DIV_W'(1) : div_scaled;
`endif
          end
        end
        S_WON, S_LOST: begin
        end
        default: begin
          state_n = S_COUNT;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_COUNT;
      counter_q <= '0;
      lives_q   <= LIVES_INIT;
      level_q   <= '0;
      hit_q     <= 1'b0;
      miss_q    <= 1'b0;
      btn_q     <= 1'b1;
`ifdef LEVEL_SPEEDUP_EN
      div       <= DIV_INIT;
`endif
    end else begin
      state     <= state_n;
      counter_q <= counter_n;
      lives_q   <= lives_n;
      level_q   <= level_n;
      hit_q     <= hit_n;
      miss_q    <= miss_n;
      btn_q     <= gif.restart | gif.stop_btn;
`ifdef LEVEL_SPEEDUP_EN
      div       <= div_n;
`endif
    end
  end

  assign bar_full       = therm(lives_q);
  assign unused_bar     = ^bar_full;
  assign gif.lives_bar  = bar_full[LIVES-1:0];
  assign gif.counter    = counter_q;
  assign gif.level      = level_q;
  assign gif.hit_pulse  = hit_q;
  assign gif.miss_pulse = miss_q;
  assign gif.won_led    = (state == S_WON);
  assign gif.lost_led   = (state == S_LOST);
endmodule

// File: tb/tb_stop_game_core.sv
// tb/tb_stop_game_core.sv - randomized scoreboard bench for stop_game_core
module tb_stop_game_core;
  localparam int CNT_W    = 4;
  localparam int TARGET   = 9;
  localparam int LIVES    = 4;
  localparam int LEVELS   = 3;
  localparam int TICK_DIV = 3;
  localparam int NV       = 1 << CNT_W;

  logic clk = 1'b0;
  logic rst;

  stop_game_if #(.CNT_W(CNT_W), .LIVES(LIVES), .LEVELS(LEVELS)) gif ();

  stop_game_core #(
    .CNT_W(CNT_W), .TARGET(TARGET), .LIVES(LIVES), .LEVELS(LEVELS), .TICK_DIV(TICK_DIV)
  ) dut (
    .clk (clk),
    .rst (rst),
    .gif (gif)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit hit;
    int cnt;
    int at;
    int lives;
    int level;
    bit won;
    bit lost;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;
  int   m_lives;
  int   m_level;
  int   c0;
  int   last_v;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    vectors++;
    if (act !== exp_v) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  function automatic int bar_of(input int l);
    return (1 << l) - 1;
  endfunction

  function automatic int mdiv();
    int d;
    d = TICK_DIV;
`ifdef LEVEL_SPEEDUP_EN
    d = TICK_DIV >> m_level;
    if (d < 1) d = 1;
`endif
    return d;
  endfunction

  // Monitor: every pulse the DUT emits must match the oldest expected judgement.
  always @(negedge clk) begin
    if (!rst && (gif.hit_pulse || gif.miss_pulse)) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", 32'(gif.hit_pulse | gif.miss_pulse), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("pulse_cycle", 32'(cyc), 32'(mon_e.at));
        chk("hit_pulse", 32'(gif.hit_pulse), 32'(mon_e.hit));
        chk("miss_pulse", 32'(gif.miss_pulse), 32'(!mon_e.hit));
        chk("judged_counter", 32'(gif.counter), 32'(mon_e.cnt));
        chk("lives_bar", 32'(gif.lives_bar), 32'(bar_of(mon_e.lives)));
        chk("level", 32'(gif.level), 32'(mon_e.level));
        chk("won_led", 32'(gif.won_led), 32'(mon_e.won));
        chk("lost_led", 32'(gif.lost_led), 32'(mon_e.lost));
      end
    end
  end

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_counter"}, 32'(gif.counter), 32'd0);
    chk({tag, "_lives_bar"}, 32'(gif.lives_bar), 32'(bar_of(LIVES)));
    chk({tag, "_level"}, 32'(gif.level), 32'd0);
    chk({tag, "_won"}, 32'(gif.won_led), 32'd0);
    chk({tag, "_lost"}, 32'(gif.lost_led), 32'd0);
  endtask

  // Counter value in round cycle j is floor(j/div) mod 2^CNT_W; press when it shows v.
  task automatic play_round(input bit want_hit, input int kmin, output bit over);
    int d, v, k, n, h;
    d = mdiv();
    if (want_hit) begin
      v = TARGET;
    end else begin
      v = int'($urandom_range(0, NV - 1));
      if (v == TARGET) v = (v + 1) % NV;
    end
    k = (v + NV * int'($urandom_range(0, 1))) * d + int'($urandom_range(0, d - 1));
    if (k < kmin) k += NV * d;
    wait_cyc(c0 + k);
    gif.stop_btn = 1'b1;
    n = cyc;
    if (want_hit) m_level++;
    else m_lives--;
    sb.push_back('{want_hit, v, n + 2, m_lives, m_level, m_level == LEVELS, m_lives == 0});
    over   = (m_level == LEVELS) || (m_lives == 0);
    last_v = v;
    h = int'($urandom_range(1, 4));
    wait_cyc(n + h);
    gif.stop_btn = 1'b0;
    c0 = ((h < 2) ? n + 2 : n + h) + 1;
  endtask

  task automatic finish_game();
    int m;
    wait_cyc(cyc + 4);
    chk("end_won_led", 32'(gif.won_led), 32'(m_level == LEVELS));
    chk("end_lost_led", 32'(gif.lost_led), 32'(m_lives == 0));
    chk("end_lives_bar", 32'(gif.lives_bar), 32'(bar_of(m_lives)));
    chk("end_counter", 32'(gif.counter), 32'(last_v));
    chk("end_sb_empty", 32'(sb.size()), 32'd0);
    repeat (2) begin
      wait_cyc(cyc + 2);
      gif.stop_btn = 1'b1;
      wait_cyc(cyc + 2);
      gif.stop_btn = 1'b0;
    end
    wait_cyc(cyc + 3);
    chk("frozen_counter", 32'(gif.counter), 32'(last_v));
    chk("frozen_won_led", 32'(gif.won_led), 32'(m_level == LEVELS));
    gif.restart = 1'b1;
    m = cyc;
    wait_cyc(m + 1);
    gif.restart  = 1'b0;
    gif.stop_btn = 1'b1;
    check_idle("restart");
    m_lives = LIVES;
    m_level = 0;
    c0 = m + 1;
    wait_cyc(m + 3);
    gif.stop_btn = 1'b0;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit over;
    int kmin;
    int rounds;
    bit want;
    rst = 1'b1;
    gif.stop_btn = 1'b1;
    gif.restart  = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    chk("reset_hit", 32'(gif.hit_pulse), 32'd0);
    chk("reset_miss", 32'(gif.miss_pulse), 32'd0);
    rst = 1'b0;
    c0 = cyc;
    m_lives = LIVES;
    m_level = 0;
    wait_cyc(c0 + 3);
    gif.stop_btn = 1'b0;
    kmin = 5;

    for (int g = 0; g < 6; g++) begin
      over   = 1'b0;
      rounds = 0;
      while (!over) begin
        if (g == 0) want = 1'b0;
        else if (g == 1) want = 1'b1;
        else if (g == 2 && rounds < 2) want = (rounds == 1);
        else want = bit'($urandom_range(0, 1));
        play_round(want, kmin, over);
        kmin = 1;
        rounds++;
        if (g == 2 && rounds == 2) begin
          wait_cyc(c0 + 3);
          rst = 1'b1;
          #1;
          check_idle("async_rst");
          chk("async_rst_hit", 32'(gif.hit_pulse | gif.miss_pulse), 32'd0);
          m_lives = LIVES;
          m_level = 0;
          @(negedge clk);
          rst = 1'b0;
          c0 = cyc;
        end
      end
      finish_game();
      kmin = 3;
    end

    wait_cyc(cyc + 6);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/stop_game_core.md
Name: stop_game_core

Overview:
- Parametrised successor to the single-round "stop the counter" game.
- Free-running counter advances on a prescaled tick; the player presses `stop_btn` to freeze it.
- A stop on `TARGET` clears a level; any other value costs a life.
- Clearing `LEVELS` levels wins the game; losing all lives loses it. Terminal states exit only on `restart` or `rst`. Drives board LEDs and a counter display.

Parameters:
- CNT_W, 4, counter width; counter wraps at 2^CNT_W-1 -> 0.
- TARGET, 9, winning stop value; must be < 2^CNT_W.
- LIVES, 4, initial lives, 1..8.
- LEVELS, 3, hits needed to win, >=1.
- TICK_DIV, 1, clk cycles per counter step, >=1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- stop_btn  in  1  player stop input; already synchronised; level-sensitive.
- restart  in  1  synchronous restart; valid in any state.
- counter  out  CNT_W  current counter value.
- lives_bar  out  LIVES  thermometer; bit i = 1 iff i < lives.
- level  out  $clog2(LEVELS+1)  levels cleared so far.
- hit_pulse  out  1  one-cycle pulse on a correct stop.
- miss_pulse  out  1  one-cycle pulse on a wrong stop.
- won_led  out  1  high in WON.
- lost_led  out  1  high in LOST; all `lives_bar` bits 0.

Behaviour:
- Reset / restart values:
  - state=COUNT, counter=0, lives=LIVES, level=0, prescaler=0, pulses=0.
  - btn_q=1, so a button already held at reset cannot trigger a stop.
  - `restart` does the same initialisation synchronously.
  - `restart` has priority over every other event in that cycle.
- Stop edge: stop_edge = stop_btn & ~btn_q; btn_q registers `stop_btn` every cycle.
- Prescaler: counts 0..div-1 in COUNT only. tick = (prescaler==div-1). Cleared on entering COUNT.
- COUNT:
  - On tick: counter <= counter+1, modulo 2^CNT_W.
  - On stop_edge: go to JUDGE; counter holds. A stop_edge in the same cycle as a tick suppresses that increment.
- JUDGE (exactly 1 cycle):
  - Hit, counter==TARGET: hit_pulse=1 next cycle; level+1. If new level==LEVELS -> WON, else RELEASE.
  - Miss: miss_pulse=1 next cycle; lives-1. If lives was 1 -> LOST, else RELEASE.
  - Lives never underflow.
- RELEASE: wait until stop_btn==0. Then counter<=0, prescaler<=0 -> COUNT. Holding the button never re-triggers.
- WON / LOST: terminal; counter frozen at its last value; only `restart`/`rst` exit.
- Latency: stop_edge at cycle n -> hit_pulse/miss_pulse at n+2 -> lives/level updated at n+2.
- `rst` mid-round: asynchronous return to reset values; no pulse emitted.
- Outputs are registered except `lives_bar`, `won_led` and `lost_led`, which decode registered state.

Optional Feature:
- Macro LEVEL_SPEEDUP_EN.
  - Defined: div = max(1, TICK_DIV >> level); each cleared level doubles the counting speed. `div` is recomputed when entering COUNT.
  - Undefined: div = TICK_DIV constant; no shifter logic is generated.

Decomposition:
- Package stop_game_pkg:
  - State enum {COUNT, JUDGE, RELEASE, WON, LOST}, 3 bits.
  - Function therm(lives) -> LIVES-bit bar.
  - Width helper for `level`.
- Sub-module tick_prescaler:
  - Ports: clk, rst, clr, en, div in, tick out.
  - Reused by future timed blocks.

Test Plan:
- Defaults, TICK_DIV=1: release reset, press stop_btn when counter=9 -> hit_pulse at +2 cycles, level=1, state RELEASE. Release button -> counter=0, counting resumes.
- Defaults: stop at counter=5 four times -> lives_bar 1111->0111->0011->0001->0000, then LOST, lost_led=1. Further presses produce no pulses.
- Hit 3 times -> WON, won_led=1, counter frozen at 9. Assert restart -> counter=0, lives_bar=1111, level=0, COUNT.
- Hold stop_btn high through reset deassertion -> no JUDGE until a release and re-press. Hold through RELEASE -> no extra miss.
- TICK_DIV=3: counter steps every 3 clk cycles. Wrap 15->0 observed. Stop edge coinciding with a tick -> counter unchanged.
- LEVEL_SPEEDUP_EN, TICK_DIV=4: step period 4, then 2, then 1 cycles after 0, 1 and 2 cleared levels. rst asserted mid-COUNT -> immediate reset values.
